axilite_write_data: RTL

- AXI4-Lite write-side responder (AW, W and B channels) for the coprocessor's memory-mapped register bank.
- Accepts an address beat and a data beat in either order, merges the bytes into a flat DATA_SIZE-bit register image, then returns a write response.
- Its `data` output is the image that the read-side responder serves back to the host.

---
 rtl/axilite_pkg.sv | 19 +
 rtl/axilite_wstrb_merge.sv | 34 +++
 rtl/axilite_write_data.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions for the coprocessor register-bank responders.
// Holds response codes, bus/strobe widths and the write-side FSM encoding.
package axilite_pkg;

  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // RESP is entered on the commit edge and is what drives bvalid.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } wr_state_t;

endpackage

// File: rtl/axilite_wstrb_merge.sv
// Byte-enable merge of one bus word into the flat register image.
// Only the word selected by word_idx is touched; others pass through.
module axilite_wstrb_merge
  import axilite_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 128,
  parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int unsigned WIDX_W     = 2
) (
  input  logic [DATA_SIZE-1:0]    cur_data,
  input  logic [WIDX_W-1:0]       word_idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_SIZE-1:0]    merged
);

  localparam int unsigned NWORDS = DATA_SIZE / DATA_WIDTH;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  // Replace each enabled byte of the selected word with the incoming byte.
  always_comb begin
    merged = cur_data;
    for (int unsigned w = 0; w < NWORDS; w++) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if ((WIDX_W'(w) == word_idx) && wstrb[b]) begin
          merged[w*DATA_WIDTH + 8*b +: 8] = wdata[8*b +: 8];
        end else begin
          merged[w*DATA_WIDTH + 8*b +: 8] = cur_data[w*DATA_WIDTH + 8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axilite_write_data.sv
// AXI4-Lite write responder: collects AW and W beats in any order, merges them
// into the register image and returns a B response (SLVERR on bad address).
module axilite_write_data
  import axilite_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 128,
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_SIZE-1:0]    awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [DATA_SIZE-1:0]    data,
  output logic                    wr_commit,
  output logic [ADDR_SIZE-1:0]    wr_word
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned NWORDS = DATA_SIZE / DATA_WIDTH;
  localparam int unsigned WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned BSHIFT = $clog2(STRB_W);
  localparam logic [ADDR_SIZE+2:0] MAX_BIT_OFS = (ADDR_SIZE+3)'(DATA_SIZE - DATA_WIDTH);
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK  = ADDR_SIZE'(STRB_W - 1);

  wr_state_t              state_r;
  wr_state_t              state_nxt_s;
  logic                   aw_got_r;
  logic                   w_got_r;
  logic [ADDR_SIZE-1:0]   awaddr_r;
  logic [DATA_WIDTH-1:0]  wdata_r;
  logic [STRB_W-1:0]      wstrb_r;
  logic [DATA_SIZE-1:0]   data_r;
  logic [1:0]             bresp_r;
  logic                   wr_commit_r;
  logic [ADDR_SIZE-1:0]   wr_word_r;

  logic                   awready_s;
  logic                   wready_s;
  logic                   bvalid_s;
  logic                   aw_fire_s;
  logic                   w_fire_s;
  logic                   commit_s;
  logic [ADDR_SIZE-1:0]   eff_addr_s;
  logic [DATA_WIDTH-1:0]  eff_wdata_s;
  logic [STRB_W-1:0]      eff_wstrb_s;
  logic [ADDR_SIZE+2:0]   addr_bits_s;
  logic                   addr_ok_s;
  logic [ADDR_SIZE-1:0]   word_idx_s;
  logic [DATA_SIZE-1:0]   merged_s;

  assign aw_fire_s = awvalid & awready_s;
  assign w_fire_s  = wvalid & wready_s;
  assign commit_s  = (aw_got_r | aw_fire_s) & (w_got_r | w_fire_s);

  // A beat arriving on the commit edge is used directly, not via its holding register.
  assign eff_addr_s  = aw_got_r ? awaddr_r : awaddr;
  assign eff_wdata_s = w_got_r  ? wdata_r  : wdata;
  assign eff_wstrb_s = w_got_r  ? wstrb_r  : wstrb;

  // Bit offset is widened by 3 bits so huge byte addresses cannot wrap into range.
  assign addr_bits_s = {eff_addr_s, 3'b000};
  assign addr_ok_s   = (addr_bits_s <= MAX_BIT_OFS) && ((eff_addr_s & ALIGN_MASK) == '0);
  assign word_idx_s  = eff_addr_s >> BSHIFT;

  axilite_wstrb_merge #(
    .DATA_SIZE  (DATA_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .WIDX_W     (WIDX_W)
  ) u_merge (
    .cur_data (data_r),
    .word_idx (word_idx_s[WIDX_W-1:0]),
    .wdata    (eff_wdata_s),
    .wstrb    (eff_wstrb_s),
    .merged   (merged_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (commit_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (bready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: readies depend only on registered state, never on valids.
  always_comb begin
    bvalid_s  = 1'b0;
    awready_s = 1'b0;
    wready_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        awready_s = ~aw_got_r;
        wready_s  = ~w_got_r;
      end
      ST_RESP: bvalid_s = 1'b1;
      default: bvalid_s = 1'b0;
    endcase
  end

  // Capture flags: set on handshake, cleared by the commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got_r <= 1'b0;
      w_got_r  <= 1'b0;
    end else if (commit_s) begin
      aw_got_r <= 1'b0;
      w_got_r  <= 1'b0;
    end else begin
      if (aw_fire_s) aw_got_r <= 1'b1;
      if (w_fire_s)  w_got_r  <= 1'b1;
    end
  end

  // Holding registers for a beat that arrives before its partner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awaddr_r <= '0;
      wdata_r  <= '0;
      wstrb_r  <= '0;
    end else begin
      if (aw_fire_s) awaddr_r <= awaddr;
      if (w_fire_s) begin
        wdata_r <= wdata;
        wstrb_r <= wstrb;
      end
    end
  end

  // Commit: update image, response code and word index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r      <= '0;
      bresp_r     <= RESP_OKAY;
      wr_commit_r <= 1'b0;
      wr_word_r   <= '0;
    end else begin
      wr_commit_r <= commit_s;
      if (commit_s) begin
        bresp_r <= addr_ok_s ? RESP_OKAY : RESP_SLVERR;
        if (addr_ok_s) begin
          data_r    <= merged_s;
          wr_word_r <= word_idx_s;
        end
      end
    end
  end

  assign awready   = awready_s;
  assign wready    = wready_s;
  assign bvalid    = bvalid_s;
  assign bresp     = bresp_r;
  assign data      = data_r;
  assign wr_commit = wr_commit_r;
  assign wr_word   = wr_word_r;

endmodule
